// File: rtl/light_dimmer_ctrl_if.sv
// Button/lamp side signal bundle for the dimmer: raw buttons and mode in, lamp drive and status out.
interface light_dimmer_ctrl_if #(
  parameter int PWM_BITS = 10,
  parameter int LEVELS   = 5
);
  logic                      i_btn_up;
  logic                      i_btn_down;
  logic                      i_btn_off;
  logic                      i_fade_en;
  logic                      o_pwm;
  logic [$clog2(LEVELS)-1:0] o_level;
  logic [PWM_BITS-1:0]       o_duty;
  logic                      o_busy;

  modport master (
    output i_btn_up, i_btn_down, i_btn_off, i_fade_en,
    input  o_pwm, o_level, o_duty, o_busy
  );

  modport slave (
    input  i_btn_up, i_btn_down, i_btn_off, i_fade_en,
    output o_pwm, o_level, o_duty, o_busy
  );
endinterface

// File: rtl/light_dimmer_ctrl.sv
// Single-lamp dimmer: debounced up/down/off buttons, saturating level, optional soft fade, PWM drive.
// Debounce timing: a raw change first sampled at rising edge k, held stable, raises the press pulse
// after edge k+DEBOUNCE_CYCLES+1; the level register moves at edge k+DEBOUNCE_CYCLES+2.
//
// Fade engine states:
//   state     | meaning
//   IDLE      | applied duty equals target, nothing to do
//   RAMP_UP   | duty below target, raised at each PWM period boundary
//   RAMP_DOWN | duty above target, lowered at each PWM period boundary
module light_dimmer_ctrl #(
  parameter int CLK_DIV         = 100,
  parameter int PWM_BITS        = 10,
  parameter int LEVELS          = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FADE_STEP       = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  light_dimmer_ctrl_if.slave  bus
);

  localparam int LVL_W = $clog2(LEVELS);
  localparam int PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAX_I = (1 << PWM_BITS) - 1;

  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP_N   = PWM_BITS'(FADE_STEP);
  localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS+1)'(FADE_STEP);
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic [DB_W-1:0]     DB_LOAD  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LVL_W-1:0]    LVL_TOP  = LVL_W'(LEVELS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } fade_state_t;

  // bit 0 = up, bit 1 = down, bit 2 = off
  logic [2:0]            w_raw;
  logic [2:0]            r_sync1;
  logic [2:0]            r_sync2;
  logic [2:0]            r_acc;
  logic [2:0]            r_pulse;
  logic [2:0][DB_W-1:0]  r_db_cnt;

  logic [LVL_W-1:0]      r_level;
  logic [PS_W-1:0]       r_presc;
  logic [PWM_BITS-1:0]   r_cnt;
  logic [PWM_BITS-1:0]   r_duty;
  logic                  r_pwm;
  logic                  r_busy;
  fade_state_t           r_state;

  logic                  w_tick;
  logic                  w_pb;
  logic [PWM_BITS-1:0]   w_cnt_next;
  logic [PWM_BITS-1:0]   w_target;
  logic [PWM_BITS-1:0]   w_target_tbl [LEVELS];
  logic [PWM_BITS-1:0]   w_duty_next;
  logic [PWM_BITS:0]     w_sum;
  logic [PWM_BITS:0]     w_floor;
  fade_state_t           w_state_next;

  assign w_raw = {bus.i_btn_off, bus.i_btn_down, bus.i_btn_up};

  // Stability timer reloads while the synchronised input agrees with the accepted state,
  // so any bounce back restarts the full wait.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_acc    <= '0;
      r_pulse  <= '0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int b = 0; b < 3; b++) begin
        r_pulse[b] <= 1'b0;
        if (r_sync2[b] == r_acc[b]) begin
          r_db_cnt[b] <= DB_LOAD;
        end else if (r_db_cnt[b] != '0) begin
          r_db_cnt[b] <= r_db_cnt[b] - DB_W'(1);
        end else begin
          r_acc[b]    <= r_sync2[b];
          r_pulse[b]  <= r_sync2[b];
          r_db_cnt[b] <= DB_LOAD;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_level <= '0;
    end else if (r_pulse[2]) begin
      r_level <= '0;
    end else if (r_pulse[1]) begin
      if (r_level != '0) r_level <= r_level - LVL_W'(1);
    end else if (r_pulse[0]) begin
      if (r_level != LVL_TOP) r_level <= r_level + LVL_W'(1);
    end
  end

  for (genvar g = 0; g < LEVELS; g++) begin : g_target
    assign w_target_tbl[g] = PWM_BITS'((g * MAX_I) / (LEVELS - 1));
  end

  assign w_target = w_target_tbl[r_level];

  assign w_tick     = (r_presc == PS_LAST);
  assign w_pb       = w_tick && (r_cnt == MAX);
  assign w_cnt_next = w_tick ? r_cnt + PWM_BITS'(1) : r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_duty  <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
      r_duty  <= w_duty_next;
      r_pwm   <= (w_duty_next == MAX) || (w_cnt_next < w_duty_next);
    end
  end

  // A direction mismatch is resolved before any duty update, so a reversed target never jumps.
  always_comb begin
    w_state_next = r_state;
    w_duty_next  = r_duty;
    w_sum        = {1'b0, r_duty} + STEP_W;
    w_floor      = {1'b0, w_target} + STEP_W;
    case (r_state)
      IDLE: begin
        if (w_target > r_duty)      w_state_next = RAMP_UP;
        else if (w_target < r_duty) w_state_next = RAMP_DOWN;
      end
      RAMP_UP: begin
        if (w_target < r_duty) begin
          w_state_next = RAMP_DOWN;
        end else if (w_target == r_duty) begin
          w_state_next = IDLE;
        end else if (w_pb) begin
          if (!bus.i_fade_en || (w_sum >= {1'b0, w_target})) begin
            w_duty_next  = w_target;
            w_state_next = IDLE;
          end else begin
            w_duty_next  = w_sum[PWM_BITS-1:0];
          end
        end
      end
      RAMP_DOWN: begin
        if (w_target > r_duty) begin
          w_state_next = RAMP_UP;
        end else if (w_target == r_duty) begin
          w_state_next = IDLE;
        end else if (w_pb) begin
          if (!bus.i_fade_en || ({1'b0, r_duty} <= w_floor)) begin
            w_duty_next  = w_target;
            w_state_next = IDLE;
          end else begin
            w_duty_next  = r_duty - STEP_N;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.o_pwm   = r_pwm;
  assign bus.o_level = r_level;
  assign bus.o_duty  = r_duty;
  assign bus.o_busy  = r_busy;

endmodule

// File: doc/light_dimmer_ctrl.md
Name: light_dimmer_ctrl

Overview:
Single-lamp dimmer controller: the successor to the fixed 4-level light stand. It has a parametrised level count, PWM resolution and prescaler. It adds integrated button debouncing, saturating up/down/off level control and an optional soft-fade ramp. Duty updates only at PWM period boundaries, so the output is glitch-free. It sits between the board push-buttons and the lamp driver pin.

Parameters:
CLK_DIV, 100, i_clk cycles per PWM counter tick (>=1)
PWM_BITS, 10, PWM counter/duty width; MAX = 2^PWM_BITS-1
LEVELS, 5, number of brightness levels including off (>=2)
DEBOUNCE_CYCLES, 1000000, i_clk cycles a synchronised button must be stable before it is accepted
FADE_STEP, 8, duty change per PWM period while fading (1..MAX)

Ports:
i_clk  in  1  system clock
i_reset  in  1  reset, asynchronous, active-low
i_btn_up  in  1  raw button, active-high, asynchronous
i_btn_down  in  1  raw button, active-high, asynchronous
i_btn_off  in  1  raw button, active-high, asynchronous
i_fade_en  in  1  1 = soft ramp, 0 = step change; synchronous level
o_pwm  out  1  lamp drive, registered
o_level  out  $clog2(LEVELS)  current selected level
o_duty  out  PWM_BITS  currently applied duty
o_busy  out  1  high while fade engine is not IDLE

Behaviour:
- Reset (i_reset=0, async): all registers clear. o_pwm=0, o_level=0, o_duty=0, o_busy=0, prescaler=0, PWM counter=0, debouncers at stable-0. No button pulse is produced on reset release.
- Prescaler: counts 0..CLK_DIV-1; tick is high in the cycle count==CLK_DIV-1, then the count wraps to 0. With CLK_DIV=1, tick is high every cycle.
- PWM counter: increments on tick and wraps MAX->0. Period boundary (pb) = tick while counter==MAX.
- o_pwm register next value: 1 if duty==MAX, else (counter_next < duty). So duty 0 gives constant low and duty MAX gives constant high.
- Debouncer, one per button:
  - 2-flop synchroniser, then a stability counter.
  - The accepted state changes after DEBOUNCE_CYCLES consecutive cycles of an unchanged synchronised value.
  - A 0->1 change in accepted state gives a 1-cycle press pulse. Releases produce nothing.
  - Latency from the raw edge to the pulse is DEBOUNCE_CYCLES+3 cycles (±1, documented exactly in RTL header).
- Level register, updated the cycle after a pulse. Priority in the same cycle: off > down > up.
  - off: level=0.
  - down: level-1, saturates at 0.
  - up: level+1, saturates at LEVELS-1.
- Target duty = (level*MAX)/(LEVELS-1), truncated. Computed as an elaboration-time constant table, with no runtime divider.
- Fade engine states: IDLE, RAMP_UP, RAMP_DOWN. It is evaluated every cycle; duty changes only on pb.
  - IDLE: duty==target. Go to RAMP_UP if target>duty, or RAMP_DOWN if target<duty.
  - i_fade_en=0: on the next pb, duty=target and the state returns to IDLE. This also applies mid-ramp.
  - RAMP_UP: on each pb, duty=min(duty+FADE_STEP, target). Use a PWM_BITS+1 wide sum so there is no wrap.
  - RAMP_DOWN: on each pb, duty=max(duty-FADE_STEP, target). The compare is done before subtracting, so there is no underflow.
  - A target change mid-ramp re-evaluates direction on the next cycle. The ramp continues from the current duty and never jumps.
  - Return to IDLE when duty==target after the update.
- o_busy = (state != IDLE). It is registered together with the state.
- o_duty reflects the applied duty register, not the target.
- Reset asserted mid-ramp or mid-debounce: immediate async clear, then normal restart.

Test Plan:
Bench parameters for all scenarios: CLK_DIV=4, PWM_BITS=4 (MAX=15, period 64 clk), LEVELS=4 (targets 0,5,10,15), DEBOUNCE_CYCLES=4, FADE_STEP=2.
1. Reset and idle: hold i_reset=0 for 5 cycles, then release with no buttons for 200 cycles -> o_pwm=0, o_level=0, o_duty=0 and o_busy=0 throughout.
2. Debounce: pulse i_btn_up high for 3 cycles, then bounce it 1-0-1, then hold 10 cycles -> exactly one level increment (o_level=1). The short glitch alone gives no change. At the next pb o_duty=5 (fade off), and o_pwm is high 5 of every 16 ticks.
3. Saturation and priority: press up 5 times -> o_level=3 and o_duty=15, with o_pwm constant 1. Press up and off simultaneously -> o_level=0. Press down at level 0 -> stays 0.
4. Fade: i_fade_en=1, level 0->2 (target 10) -> o_busy=1. o_duty steps 2,4,6,8,10 on consecutive pbs, then o_busy=0. Press down to level 1 (target 5) -> o_duty 8,6,5 then IDLE.
5. Mid-ramp mode switch: start a ramp 0->15 with fade on. Clear i_fade_en after o_duty=4 -> the next pb gives o_duty=15 and o_busy=0. No intermediate value appears.
6. Async reset mid-ramp: assert i_reset during RAMP_UP, off a clock edge -> all outputs 0 immediately. After release, the level stays 0 until a new press.
